// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: sequential radix-2 shift-add multiplier.
// Retires one multiplier bit per clock (latency WIDTH+1 start->done), with a
// start/busy/done handshake, a held registered product and an exposed FSM state.
// Optional build macro SEQ_MUL_SIGNED_EN adds the `sgn` input for two's-complement
// operands (magnitudes multiplied, sign applied on the DONE-entry edge).
module seq_shift_add_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MUL_SIGNED_EN
   input  logic                 sgn,
`endif
   output logic [2*WIDTH-1:0]   y,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           state
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplr_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   acc_sum;
   logic [2*WIDTH-1:0]   result;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
`ifdef SEQ_MUL_SIGNED_EN
   logic                 neg_in;
   logic                 neg_q;
`endif

   // Operand conditioning at capture: magnitudes for signed mode, pass-through otherwise
   always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
      a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
      b_mag  = (sgn && b[WIDTH-1]) ? -b : b;
      neg_in = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
      a_mag  = a;
      b_mag  = b;
`endif
   end

   // One shift-add step and the final (optionally negated) product
   always_comb begin
      acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
`ifdef SEQ_MUL_SIGNED_EN
      result  = neg_q ? -acc_sum : acc_sum;
`else
      result  = acc_sum;
`endif
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: IDLE -> CALC on start, CALC -> DONE after WIDTH steps, DONE -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, and product register
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         y       <= '0;
`ifdef SEQ_MUL_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q <= {{WIDTH{1'b0}}, a_mag};
                  mplr_q  <= b_mag;
                  acc_q   <= '0;
                  cnt_q   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
                  neg_q   <= neg_in;
`endif
               end
            end
            CALC: begin
               acc_q   <= acc_sum;
               mcand_q <= mcand_q << 1;
               mplr_q  <= mplr_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST) y <= result;
            end
            default: ;
         endcase
      end
   end

   // Status outputs decoded from the state register
   always_comb begin
      busy  = (state_q == CALC);
      done  = (state_q == DONE);
      state = {2'b00, state_q};
   end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed self-checking bench for the shift-add
// multiplier, using a 4-bit and an 8-bit instance on a shared clock and reset.
module tb_seq_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic [7:0]  y4;
   logic        busy4;
   logic        done4;
   logic [3:0]  state4;
   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [15:0] y8;
   logic        busy8;
   logic        done8;
   logic [3:0]  state8;
`ifdef SEQ_MUL_SIGNED_EN
   logic        sgn4 = 1'b0;
   logic        sgn8 = 1'b0;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;

   seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .a     (a4),
      .b     (b4),
`ifdef SEQ_MUL_SIGNED_EN
      .sgn   (sgn4),
`endif
      .y     (y4),
      .busy  (busy4),
      .done  (done4),
      .state (state4)
   );

   seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
`ifdef SEQ_MUL_SIGNED_EN
      .sgn   (sgn8),
`endif
      .y     (y8),
      .busy  (busy8),
      .done  (done8),
      .state (state8)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full 4-bit transaction from IDLE: handshake timing plus held product
   task automatic run4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic sv, input logic [7:0] exp);
      a4 = av;
      b4 = bv;
`ifdef SEQ_MUL_SIGNED_EN
      sgn4 = sv;
`else
      if (sv) $display("note: %s requests signed mode in unsigned build", tag);
`endif
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_busy"}, 32'(busy4), 32'd1);
         check({tag, "_nodone"}, 32'(done4), 32'd0);
         step();
      end
      check({tag, "_done"}, 32'(done4), 32'd1);
      check({tag, "_dbusy"}, 32'(busy4), 32'd0);
      check({tag, "_dstate"}, 32'(state4), 32'd2);
      check({tag, "_y"}, 32'(y4), 32'(exp));
      step();
      check({tag, "_done_clr"}, 32'(done4), 32'd0);
      check({tag, "_idle"}, 32'(state4), 32'd0);
      check({tag, "_yheld"}, 32'(y4), 32'(exp));
   endtask

   initial begin
      // Initial reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_y4", 32'(y4), 32'd0);
      check("rst_state4", 32'(state4), 32'd0);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_y8", 32'(y8), 32'd0);

      // Random activity then reset held 3 cycles
      for (int i = 0; i < 5; i++) begin
         start4 = 1'(i % 2);
         a4 = 4'($urandom);
         b4 = 4'($urandom);
         start8 = 1'b1;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         step();
      end
      start4 = 1'b0;
      start8 = 1'b0;
      rst = 1'b1;
      step();
      step();
      step();
      rst = 1'b0;
      check("rst3_y4", 32'(y4), 32'd0);
      check("rst3_busy4", 32'(busy4), 32'd0);
      check("rst3_done4", 32'(done4), 32'd0);
      check("rst3_state4", 32'(state4), 32'd0);
      check("rst3_state8", 32'(state8), 32'd0);
      check("rst3_y8", 32'(y8), 32'd0);

      // Full-scale and zero-operand 4-bit products
      run4("m15x15", 4'd15, 4'd15, 1'b0, 8'd225);
      run4("m9x0", 4'd9, 4'd0, 1'b0, 8'd0);
      run4("m0x7", 4'd0, 4'd7, 1'b0, 8'd0);
      run4("m1x1", 4'd1, 4'd1, 1'b0, 8'd1);
      run4("m6x5", 4'd6, 4'd5, 1'b0, 8'd30);

      // 8-bit: start re-pulsed and operands changed mid-CALC, start in DONE ignored
      a8 = 8'd200;
      b8 = 8'd3;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("w8_busy", 32'(busy8), 32'd1);
         if (i == 2 || i == 5) begin
            start8 = 1'b1;
            a8 = 8'd77;
            b8 = 8'd99;
         end else begin
            start8 = 1'b0;
         end
         step();
      end
      check("w8_done", 32'(done8), 32'd1);
      check("w8_y", 32'(y8), 32'd600);
      a8 = 8'd5;
      b8 = 8'd5;
      start8 = 1'b1;
      step();
      check("w8_start_in_done_ignored", 32'(state8), 32'd0);
      check("w8_no_busy", 32'(busy8), 32'd0);
      check("w8_y_held", 32'(y8), 32'd600);
      step();
      start8 = 1'b0;
      check("w8_next_accepted", 32'(busy8), 32'd1);
      for (int i = 0; i < 7; i++) step();
      check("w8_y_held_calc", 32'(y8), 32'd600);
      step();
      check("w8_done2", 32'(done8), 32'd1);
      check("w8_y2", 32'(y8), 32'd25);
      step();

      // Reset mid-CALC abandons the product
      a4 = 4'd13;
      b4 = 4'd11;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_state", 32'(state4), 32'd0);
      check("abort_y", 32'(y4), 32'd0);
      for (int i = 0; i < 6; i++) begin
         check("abort_nodone", 32'(done4), 32'd0);
         step();
      end
      run4("m13x11", 4'd13, 4'd11, 1'b0, 8'd143);

`ifdef SEQ_MUL_SIGNED_EN
      // Two's-complement products
      run4("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
      run4("s_m3x5", 4'hD, 4'h5, 1'b1, 8'hF1);
      run4("s_7xm1", 4'h7, 4'hF, 1'b1, 8'hF9);
      run4("s_u15x15", 4'hF, 4'hF, 1'b0, 8'd225);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
